i2c_master_ctrl: RTL and testbench
==================================

I2C_MASTER_CTRL -- requirements
Module: i2c_master_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250: clk cycles per SCL quarter-period (phase); legal range 2..65535.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port cmd_valid, input, 1, the requester offers a write command.
REQ-005 SHALL have port cmd_ready, output, 1, high only in IDLE; the command is accepted on the cycle where cmd_valid and cmd_ready are both high.
REQ-006 SHALL have port cmd_addr, input, 7, the target slave address.
REQ-007 SHALL have port cmd_reg, input, 8, the target register address.
REQ-008 SHALL have port cmd_data, input, 8, the data byte to write.
REQ-009 SHALL have port busy, output, 1, high from the cycle after acceptance until done.
REQ-010 SHALL have port done, output, 1, one-cycle pulse at transaction end.
REQ-011 SHALL have port nack, output, 1, valid with done: 1 means a NACK was received; held until the next acceptance.
REQ-012 SHALL have port scl_o, output, 1, the SCL level.
REQ-013 SHALL have port sda_oe, output, 1, 1 drives SDA low and 0 releases SDA (open-drain).
REQ-014 SHALL have port sda_i, input, 1, the sampled SDA line.

Function
REQ-015 SHALL latch cmd_addr/cmd_reg/cmd_data on acceptance; input changes while busy have no effect.
REQ-016 SHALL ignore cmd_valid while busy (cmd_ready=0); there is no queueing.
REQ-017 SHALL emit a phase tick every CLK_DIV clk cycles while busy, with the phase counter cleared on acceptance; each bit is 4 phases P0..P3.
REQ-018 Data bit timing SHALL be: scl_o=0 in P0-P1 and 1 in P2-P3; sda_oe updates at the start of P0; sda_i is sampled on the last clk of P2.
REQ-019 The FSM SHALL use states IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, STOP with sequence IDLE->START->ADDR->ADDR_ACK->REG->REG_ACK->DATA->DATA_ACK->STOP->IDLE.
REQ-020 START SHALL last 4 phases: scl_o=1 throughout; sda_oe=0 in P0-P1 and 1 in P2-P3.
REQ-021 ADDR SHALL shift out {cmd_addr,1'b0} (write), 8 bits, MSB first; REG and DATA SHALL each shift 8 bits MSB first; a 3-bit bit counter runs 7->0.
REQ-022 The *_ACK states SHALL last one bit with sda_oe=0; sampled sda_i=0 means ACK and the FSM continues; sda_i=1 means NACK, sets nack, and the FSM goes to STOP.
REQ-023 STOP SHALL last 4 phases: sda_oe=1 in P0-P1 with scl_o=0 in P0 and 1 in P1-P3; sda_oe=0 in P2-P3.
REQ-024 done SHALL pulse on the clk after the last STOP phase, with the FSM in IDLE that same cycle.
REQ-025 Latency from the acceptance cycle N SHALL be: full transaction, done at N+1+116*CLK_DIV; address NACK, N+1+44*CLK_DIV; register NACK, N+1+80*CLK_DIV.
REQ-026 Back-to-back operation SHALL hold: cmd_ready=1 in the done cycle, so a held cmd_valid is accepted then.
REQ-027 In IDLE the outputs SHALL be scl_o=1, sda_oe=0, busy=0.

Reset
REQ-028 Assertion of reset_n=0 SHALL immediately force: FSM=IDLE, scl_o=1, sda_oe=0, busy=0, done=0, nack=0, cmd_ready=1, counters=0, latched command=0.
REQ-029 Reset mid-transaction SHALL abandon the transfer with no STOP generated; the bus is released.
REQ-030 After reset_n deasserts, the block SHALL accept a command on the first clk edge.

Structure
REQ-031 Package i2c_pkg SHALL hold the state encoding, the constants SLAVE_ADDR=7'h4B and REG_ADDR=8'hAB, and the phase-count width.
REQ-032 Sub-module i2c_phase_gen SHALL contain the CLK_DIV counter, phase tick, and 2-bit phase index; the FSM and shifter stay in i2c_master_ctrl.

Verification
REQ-033 Scenario, full write: CLK_DIV=4, ACKing slave model; cmd 4B/AB/5A -> SDA bytes 0x96, 0xAB, 0x5A; done at N+1+464; nack=0.
REQ-034 Scenario, address NACK: cmd 0x22 to a non-responding slave -> STOP after the 9th bit; done at N+1+176; nack=1.
REQ-035 Scenario, data NACK: slave NACKs the data byte -> done at N+1+464; nack=1.
REQ-036 Scenario, reset mid-ADDR: reset_n=0 -> scl_o=1 and sda_oe=0 in the same cycle, before the next clk edge; busy=0.
REQ-037 Scenario, busy protection: cmd_valid held with changing data while busy -> no acceptance; bus bytes match the first command; the second command is accepted in the done cycle.
REQ-038 Scenario, START/STOP checker: SDA falls while SCL=1 exactly once per transaction at START, and rises while SCL=1 only at STOP.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-write master.
//   state_t     : FSM state encoding
//   i2c_cmd_t   : latched command payload (address, register, data)
//   bus_levels  : SCL / SDA-drive levels for a given state, phase and tx bit
package i2c_pkg;

  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned PH_CNT_W  = 16;
  localparam int unsigned BIT_CNT_W = 3;

  localparam logic [ADDR_W-1:0] SLAVE_ADDR = 7'h4B;
  localparam logic [BYTE_W-1:0] REG_ADDR   = 8'hAB;

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, STOP
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BYTE_W-1:0] reg_addr;
    logic [BYTE_W-1:0] data;
  } i2c_cmd_t;

  // Returns {scl, sda_oe} for the phase about to begin.
  function automatic logic [1:0] bus_levels(input state_t st, input logic [1:0] ph,
                                            input logic tx_bit);
    logic [1:0] lv;
    lv = 2'b10;
    case (st)
      START:                       lv = {1'b1, ph[1]};
      ADDR, REG, DATA:             lv = {ph[1], ~tx_bit};
      ADDR_ACK, REG_ACK, DATA_ACK: lv = {ph[1], 1'b0};
      STOP:                        lv = {(ph != 2'd0), ~ph[1]};
      default:                     lv = 2'b10;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_master_ctrl_if.sv
// Command handshake and I2C pin bundle.
//   master modport : the controller (accepts commands, drives SCL / SDA enable)
//   slave  modport : the requester / bus side
interface i2c_master_ctrl_if;
  import i2c_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BYTE_W-1:0] cmd_reg;
  logic [BYTE_W-1:0] cmd_data;
  logic              busy;
  logic              done;
  logic              nack;
  logic              scl_o;
  logic              sda_oe;
  logic              sda_i;

  modport master (
    input  cmd_valid, cmd_addr, cmd_reg, cmd_data, sda_i,
    output cmd_ready, busy, done, nack, scl_o, sda_oe
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_reg, cmd_data, sda_i,
    input  cmd_ready, busy, done, nack, scl_o, sda_oe
  );
endinterface

// File: rtl/i2c_phase_gen.sv
// SCL phase generator: divides clk by CLK_DIV into phase ticks and keeps the
// 2-bit phase index P0..P3 of the current bit.
//   i_clr    : restart counter and phase (command acceptance)
//   i_en     : count while a transfer is in progress
//   o_tick_c : last clk of the current phase
//   o_phase  : current phase index
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_en,
  output logic       o_tick_c,
  output logic [1:0] o_phase
);

  localparam logic [PH_CNT_W-1:0] LAST_CNT = PH_CNT_W'(CLK_DIV - 1);

  logic [PH_CNT_W-1:0] r_cnt;
  logic [1:0]          r_phase;

  assign o_tick_c = i_en && (r_cnt == LAST_CNT);
  assign o_phase  = r_phase;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_phase <= 2'd0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_phase <= 2'd0;
    end else if (o_tick_c) begin
      r_cnt   <= '0;
      r_phase <= r_phase + 2'd1;
    end else if (i_en) begin
      r_cnt   <= r_cnt + PH_CNT_W'(1);
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C register write master: START, {addr,W}, reg, data, STOP,
// with ACK checks after each byte; a NACK aborts straight to STOP.
//   clk, reset_n : clock, async active-low reset
//   bus          : command handshake, status and open-drain SCL/SDA pins
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic                clk,
  input  logic                reset_n,
  i2c_master_ctrl_if.master   bus
);

  state_t                 r_state, w_nxt_state;
  logic [BIT_CNT_W-1:0]   r_bit_cnt, w_nxt_bit_cnt;
  logic [BYTE_W-1:0]      r_shift, w_nxt_shift;
  i2c_cmd_t               r_cmd;
  logic                   r_ack_bit;
  logic                   r_busy, r_done, r_nack, r_cmd_ready;
  logic                   r_scl, r_sda_oe;
  logic                   w_accept, w_tick, w_bit_end, w_in_ack;
  logic                   w_nxt_scl, w_nxt_sda_oe;
  logic [1:0]             w_phase, w_nxt_phase;

  i2c_phase_gen #(.CLK_DIV(CLK_DIV)) u_phase (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_accept),
    .i_en     (r_busy),
    .o_tick_c (w_tick),
    .o_phase  (w_phase)
  );

  assign w_accept  = bus.cmd_valid && r_cmd_ready;
  assign w_bit_end = w_tick && (w_phase == 2'd3);
  assign w_in_ack  = (r_state == ADDR_ACK) || (r_state == REG_ACK) || (r_state == DATA_ACK);

  // Next state / shifter; pin levels are computed for the upcoming phase so
  // the registered outputs change exactly at phase boundaries.
  always_comb begin
    w_nxt_state   = r_state;
    w_nxt_bit_cnt = r_bit_cnt;
    w_nxt_shift   = r_shift;
    if (w_accept) begin
      w_nxt_state = START;
    end else if (w_bit_end) begin
      case (r_state)
        START: begin
          w_nxt_state   = ADDR;
          w_nxt_bit_cnt = BIT_CNT_W'(7);
          w_nxt_shift   = {r_cmd.addr, 1'b0};
        end
        ADDR, REG, DATA: begin
          if (r_bit_cnt == '0) begin
            w_nxt_state = (r_state == ADDR) ? ADDR_ACK :
                          (r_state == REG)  ? REG_ACK  : DATA_ACK;
          end else begin
            w_nxt_bit_cnt = r_bit_cnt - BIT_CNT_W'(1);
            w_nxt_shift   = {r_shift[BYTE_W-2:0], 1'b0};
          end
        end
        ADDR_ACK: begin
          w_nxt_state   = r_ack_bit ? STOP : REG;
          w_nxt_bit_cnt = BIT_CNT_W'(7);
          w_nxt_shift   = r_cmd.reg_addr;
        end
        REG_ACK: begin
          w_nxt_state   = r_ack_bit ? STOP : DATA;
          w_nxt_bit_cnt = BIT_CNT_W'(7);
          w_nxt_shift   = r_cmd.data;
        end
        DATA_ACK: w_nxt_state = STOP;
        STOP:     w_nxt_state = IDLE;
        default:  w_nxt_state = r_state;
      endcase
    end
    w_nxt_phase = w_accept ? 2'd0 : (w_tick ? w_phase + 2'd1 : w_phase);
    {w_nxt_scl, w_nxt_sda_oe} = bus_levels(w_nxt_state, w_nxt_phase, w_nxt_shift[BYTE_W-1]);
  end

  // State, command latch and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_cmd       <= '0;
      r_ack_bit   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_nack      <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_scl       <= 1'b1;
      r_sda_oe    <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_bit_cnt   <= w_nxt_bit_cnt;
      r_shift     <= w_nxt_shift;
      r_scl       <= w_nxt_scl;
      r_sda_oe    <= w_nxt_sda_oe;
      r_busy      <= (w_nxt_state != IDLE);
      r_cmd_ready <= (w_nxt_state == IDLE);
      r_done      <= (r_state == STOP) && w_bit_end;
      if (w_accept) begin
        r_cmd  <= '{addr: bus.cmd_addr, reg_addr: bus.cmd_reg, data: bus.cmd_data};
        r_nack <= 1'b0;
      end else if (w_bit_end && w_in_ack && r_ack_bit) begin
        r_nack <= 1'b1;
      end
      // ACK bit is taken on the last clk of P2 (SCL high, settled).
      if (w_tick && (w_phase == 2'd2) && w_in_ack) begin
        r_ack_bit <= bus.sda_i;
      end
    end
  end

  assign bus.cmd_ready = r_cmd_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.nack      = r_nack;
  assign bus.scl_o     = r_scl;
  assign bus.sda_oe    = r_sda_oe;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Directed bench for i2c_master_ctrl with a simple ACKing slave model and a
// START/STOP condition counter on the wired-AND SDA line.
module tb_i2c_master_ctrl;
  import i2c_pkg::*;

  localparam int unsigned CLK_DIV = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  i2c_master_ctrl_if bus();

  i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model state
  logic       slv_drv = 1'b0;
  bit         nack_reg = 1'b0;
  bit         nack_data = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic [7:0] cur = 8'h00;
  int         bit_idx = 0;
  int         byte_no = 0;
  int         start_cnt = 0;
  int         stop_cnt = 0;
  logic [7:0] rx_q[$];

  assign bus.sda_i = ~(bus.sda_oe | slv_drv);

  always @(negedge clk) begin
    if (prev_scl && bus.scl_o) begin
      if (prev_sda && !bus.sda_i) begin
        start_cnt <= start_cnt + 1;
        bit_idx   <= 0;
        byte_no   <= 0;
      end
      if (!prev_sda && bus.sda_i) stop_cnt <= stop_cnt + 1;
    end
    if (!prev_scl && bus.scl_o) begin
      if (bit_idx < 8) cur <= {cur[6:0], bus.sda_i};
      bit_idx <= bit_idx + 1;
    end
    if (prev_scl && !bus.scl_o) begin
      if (bit_idx == 8) begin
        slv_drv <= (byte_no == 0) ? (cur[7:1] == SLAVE_ADDR) :
                   (byte_no == 1) ? !nack_reg :
                   (byte_no == 2) ? !nack_data : 1'b0;
      end else if (bit_idx == 9) begin
        slv_drv <= 1'b0;
        rx_q.push_back(cur);
        byte_no <= byte_no + 1;
        bit_idx <= 0;
      end
    end
    if (!reset_n) slv_drv <= 1'b0;
    prev_scl <= bus.scl_o;
    prev_sda <= bus.sda_i;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int acc_cyc = 0;
  int base_q = 0;
  int base_start = 0;
  int base_stop = 0;

  task automatic snap();
    base_q     = rx_q.size();
    base_start = start_cnt;
    base_stop  = stop_cnt;
  endtask

  // Offer a command at a negedge; it is accepted on the following posedge.
  task automatic issue(input logic [6:0] a, input logic [7:0] r, input logic [7:0] d,
                       input bit hold);
    @(negedge clk);
    chk("ready_idle", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_reg   = r;
    bus.cmd_data  = d;
    snap();
    acc_cyc = cyc + 1;
    @(negedge clk);
    chk("busy_acc", 32'(bus.busy), 32'd1);
    chk("nack_clr", 32'(bus.nack), 32'd0);
    if (hold) begin
      bus.cmd_addr = 7'h22;
      bus.cmd_reg  = 8'h00;
      bus.cmd_data = 8'hFF;
    end else begin
      bus.cmd_valid = 1'b0;
    end
  endtask

  // Wait for done (bounded) and check the finished transaction; returns at
  // the negedge of the done cycle.
  task automatic finish_tx(input string tag, input int exp_lat, input logic exp_nack,
                           input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input int nb);
    bit         seen;
    logic [7:0] exp_b[3];
    seen = 1'b0;
    exp_b = '{b0, b1, b2};
    for (int i = 0; i < 3000; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'(exp_lat));
    chk({tag, "_nack"}, 32'(bus.nack), 32'(exp_nack));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    chk({tag, "_ready_at_done"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_scl_idle"}, 32'(bus.scl_o), 32'd1);
    chk({tag, "_sda_oe_idle"}, 32'(bus.sda_oe), 32'd0);
    chk({tag, "_byte_count"}, 32'(rx_q.size() - base_q), 32'(nb));
    if (rx_q.size() - base_q == nb) begin
      for (int i = 0; i < nb; i++) begin
        chk($sformatf("%s_byte%0d", tag, i), 32'(rx_q[base_q + i]), 32'(exp_b[i]));
      end
    end
    chk({tag, "_start_cnt"}, 32'(start_cnt - base_start), 32'd1);
    chk({tag, "_stop_cnt"}, 32'(stop_cnt - base_stop), 32'd1);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_reg   = '0;
    bus.cmd_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_scl", 32'(bus.scl_o), 32'd1);
    chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_nack", 32'(bus.nack), 32'd0);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    reset_n = 1'b1;

    // Full write: 116 phases
    issue(SLAVE_ADDR, REG_ADDR, 8'h5A, 1'b0);
    finish_tx("wr", 464, 1'b0, 8'h96, 8'hAB, 8'h5A, 3);
    @(negedge clk);
    chk("wr_done_pulse", 32'(bus.done), 32'd0);

    // Address NACK: 44 phases
    issue(7'h22, REG_ADDR, 8'h5A, 1'b0);
    finish_tx("anack", 176, 1'b1, 8'h44, 8'h00, 8'h00, 1);
    @(negedge clk);
    chk("anack_done_pulse", 32'(bus.done), 32'd0);
    repeat (5) @(negedge clk);
    chk("nack_hold", 32'(bus.nack), 32'd1);

    // Register NACK: 80 phases
    nack_reg = 1'b1;
    issue(SLAVE_ADDR, REG_ADDR, 8'h5A, 1'b0);
    finish_tx("rnack", 320, 1'b1, 8'h96, 8'hAB, 8'h00, 2);
    nack_reg = 1'b0;

    // Data NACK: full length, nack set
    nack_data = 1'b1;
    issue(SLAVE_ADDR, REG_ADDR, 8'h5A, 1'b0);
    finish_tx("dnack", 464, 1'b1, 8'h96, 8'hAB, 8'h5A, 3);
    nack_data = 1'b0;

    // Busy protection and back-to-back acceptance in the done cycle
    issue(SLAVE_ADDR, REG_ADDR, 8'h5A, 1'b1);
    repeat (100) @(negedge clk);
    chk("bp_ready_low", 32'(bus.cmd_ready), 32'd0);
    chk("bp_busy_high", 32'(bus.busy), 32'd1);
    bus.cmd_addr = SLAVE_ADDR;
    bus.cmd_reg  = 8'h11;
    bus.cmd_data = 8'hC3;
    finish_tx("bp1", 464, 1'b0, 8'h96, 8'hAB, 8'h5A, 3);
    snap();
    acc_cyc = cyc + 1;
    @(negedge clk);
    chk("bp2_accepted", 32'(bus.busy), 32'd1);
    chk("bp2_done_pulse", 32'(bus.done), 32'd0);
    bus.cmd_valid = 1'b0;
    finish_tx("bp2", 464, 1'b0, 8'h96, 8'h11, 8'hC3, 3);

    // Reset in the middle of ADDR bit 6 (a driven-low 0 bit)
    issue(SLAVE_ADDR, REG_ADDR, 8'h5A, 1'b0);
    repeat (33) @(posedge clk);
    #2;
    chk("mid_scl_low", 32'(bus.scl_o), 32'd0);
    chk("mid_sda_oe", 32'(bus.sda_oe), 32'd1);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_scl", 32'(bus.scl_o), 32'd1);
    chk("arst_sda_oe", 32'(bus.sda_oe), 32'd0);
    chk("arst_busy", 32'(bus.busy), 32'd0);
    chk("arst_ready", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = SLAVE_ADDR;
    bus.cmd_reg   = REG_ADDR;
    bus.cmd_data  = 8'h3C;
    @(negedge clk);
    reset_n = 1'b1;
    snap();
    acc_cyc = cyc + 1;
    @(negedge clk);
    chk("first_edge_accept", 32'(bus.busy), 32'd1);
    bus.cmd_valid = 1'b0;
    finish_tx("post_rst", 464, 1'b0, 8'h96, 8'hAB, 8'h3C, 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
